stream_packer: RTL and testbench

STREAM_PACKER -- requirements
Module: stream_packer

---
 rtl/stream_packer.sv | 130 +++++++++++++
 tb/tb_stream_packer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
// rtl/stream_packer.sv - MSB-first bit packer from ISIZE-bit beats into OSIZE-bit words
//
// Purpose: accumulates accepted input beats MSB-first into a bit accumulator
//   and emits full OSIZE-bit words through a single-entry output register.
//   In LINE mode a beat with ilast flushes the packet: the final word is
//   zero-padded in its LSBs and marked with olast.
// Ports:
//   clock          sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   ivalid/iready  input beat handshake; idata, ialign, ilast sampled on accept
//   ovalid/oready  output word handshake; odata, okeep, olast held while stalled
// Configuration macro: STREAM_PACKER_KEEP_EN
//   defined   - okeep marks the valid bytes of the flush word (MSB-aligned)
//   undefined - okeep tied to all ones
module stream_packer #(
  parameter int ISIZE = 24,
  parameter int OSIZE = 256,
  parameter     MODE  = "LINE"
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               ivalid,
  output logic               iready,
  input  logic [ISIZE-1:0]   idata,
  input  logic               ialign,
  input  logic               ilast,
  output logic               ovalid,
  input  logic               oready,
  output logic [OSIZE-1:0]   odata,
  output logic [OSIZE/8-1:0] okeep,
  output logic               olast
);

  localparam int AW = OSIZE + ISIZE;
  localparam int KW = OSIZE / 8;
  localparam int FW = $clog2(AW + 1);
  localparam logic [FW-1:0] OSZ = FW'(OSIZE);
  localparam logic [FW-1:0] ISZ = FW'(ISIZE);
  localparam bit LINE_MODE = (MODE == "LINE");

  // Valid bits sit in acc[AW-1 -: fill]; everything below is kept zero so the
  // flush word gets its LSB padding for free.
  logic [AW-1:0] acc;
  logic [FW-1:0] fill;
  logic          flush_pending;
  logic          run;

  logic          drain;
  logic          accept;
  logic          final_word;
  logic [FW-1:0] base;
  logic [AW-1:0] kept;
  logic [AW-1:0] beat_ext;
`ifdef STREAM_PACKER_KEEP_EN
  logic [FW-1:0] nbytes;
  logic [KW-1:0] keep_next;
`endif

  always_comb begin
    drain      = (fill >= OSZ || flush_pending) && (!ovalid || oready);
    final_word = flush_pending && (fill <= OSZ);
    // run holds iready low through reset and the first edge after it.
    iready     = run && !flush_pending && (fill < OSZ || drain);
    accept     = ivalid && iready;
    beat_ext   = {idata, {OSIZE{1'b0}}};

    // Accumulator after the (optional) drain of its top word.
    kept = drain ? (acc << OSIZE) : acc;
    base = drain ? ((fill >= OSZ) ? (fill - OSZ) : '0) : fill;

    // Align drops the partial remainder; a full word draining this cycle
    // has already been moved to the output register.
    if (accept && ialign) begin
      kept = '0;
      base = '0;
    end

`ifdef STREAM_PACKER_KEEP_EN
    nbytes    = (fill + FW'(7)) >> 3;
    keep_next = final_word ? ~({KW{1'b1}} >> nbytes) : {KW{1'b1}};
`endif
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      fill          <= '0;
      flush_pending <= 1'b0;
      run           <= 1'b0;
      ovalid        <= 1'b0;
      odata         <= '0;
      olast         <= 1'b0;
`ifdef STREAM_PACKER_KEEP_EN
      okeep         <= '0;
`endif
    end else begin
      run <= 1'b1;

      if (accept) begin
        acc  <= kept | (beat_ext >> base);
        fill <= base + ISZ;
      end else begin
        acc  <= kept;
        fill <= base;
      end

      // Accept is blocked while a flush is pending, so these never collide.
      if (drain && final_word)
        flush_pending <= 1'b0;
      else if (accept && ilast && LINE_MODE)
        flush_pending <= 1'b1;

      if (drain) begin
        ovalid <= 1'b1;
        odata  <= acc[AW-1 -: OSIZE];
        olast  <= final_word;
`ifdef STREAM_PACKER_KEEP_EN
        okeep  <= keep_next;
`endif
      end else if (oready) begin
        ovalid <= 1'b0;
      end
    end
  end

`ifndef STREAM_PACKER_KEEP_EN
  assign okeep = {KW{1'b1}};
`endif

endmodule

// File: tb/tb_stream_packer.sv
// tb/tb_stream_packer.sv - self-checking bench for stream_packer (24 -> 256, LINE)
module tb_stream_packer;

  localparam int IS = 24;
  localparam int OS = 256;
  localparam int KW = OS / 8;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          ivalid = 1'b0;
  logic          iready;
  logic [IS-1:0] idata = '0;
  logic          ialign = 1'b0;
  logic          ilast = 1'b0;
  logic          ovalid;
  logic          oready = 1'b0;
  logic [OS-1:0] odata;
  logic [KW-1:0] okeep;
  logic          olast;

  int checks = 0;
  int errors = 0;

  stream_packer #(.ISIZE(IS), .OSIZE(OS), .MODE("LINE")) dut (
    .clock (clock),
    .rst_n (rst_n),
    .ivalid(ivalid),
    .iready(iready),
    .idata (idata),
    .ialign(ialign),
    .ilast (ilast),
    .ovalid(ovalid),
    .oready(oready),
    .odata (odata),
    .okeep (okeep),
    .olast (olast)
  );

  always #5 clock = ~clock;

  // Reference model: a plain bit queue, MSB-first, plus expected-word queues.
  bit            mq[$];
  logic [OS-1:0] exp_data[$];
  logic [KW-1:0] exp_keep[$];
  logic          exp_last[$];
  logic [OS-1:0] got_data[$];
  logic [KW-1:0] got_keep[$];
  int            words_seen = 0;
  int            oready_pct = 100;
  bit            acc_flag;

  task automatic chk(input string tag, input logic [OS-1:0] got, input logic [OS-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic emit(input int n, input bit last);
    logic [OS-1:0] d;
    logic [KW-1:0] k;
    d = '0;
    for (int i = 0; i < n; i++) d[OS-1-i] = mq.pop_front();
`ifdef STREAM_PACKER_KEEP_EN
    for (int b = 0; b < KW; b++) k[KW-1-b] = (b * 8 < n);
`else
    k = '1;
`endif
    exp_data.push_back(d);
    exp_keep.push_back(k);
    exp_last.push_back(last);
  endtask

  task automatic model_accept(input logic [IS-1:0] d, input logic a, input logic l);
    if (a) mq.delete();
    for (int i = IS - 1; i >= 0; i--) mq.push_back(d[i]);
    if (l) begin
      while (mq.size() > OS) emit(OS, 1'b0);
      emit(mq.size(), 1'b1);
    end else begin
      while (mq.size() >= OS) emit(OS, 1'b0);
    end
  endtask

  task automatic check_out();
    checks++;
    assert (exp_data.size() > 0) else begin
      errors++;
      $error("FAIL unexpected_word observed %h expected none", odata);
    end
    if (exp_data.size() > 0) begin
      chk("odata", odata, exp_data.pop_front());
      chk("okeep", OS'(okeep), OS'(exp_keep.pop_front()));
      chk("olast", OS'(olast), OS'(exp_last.pop_front()));
    end
    got_data.push_back(odata);
    got_keep.push_back(okeep);
    words_seen++;
  endtask

  task automatic clk_step();
    @(negedge clock);
    acc_flag = ivalid && iready;
    if (acc_flag) model_accept(idata, ialign, ilast);
    if (ovalid && oready) check_out();
    @(posedge clock);
    #1;
    oready = ($urandom_range(0, 99) < oready_pct);
  endtask

  task automatic send(input logic [IS-1:0] d, input logic a, input logic l,
                      input int maxwait, output bit ok, output int stalls);
    ivalid = 1'b1; idata = d; ialign = a; ilast = l;
    ok = 1'b0; stalls = 0;
    for (int i = 0; i < maxwait && !ok; i++) begin
      clk_step();
      if (acc_flag) ok = 1'b1;
      else stalls++;
    end
    ivalid = 1'b0; ialign = 1'b0; ilast = 1'b0;
  endtask

  task automatic send_chk(input logic [IS-1:0] d, input logic a, input logic l, output int stalls);
    bit ok;
    send(d, a, l, 200, ok, stalls);
    if (!ok) chk("accept_timeout", OS'(ok), OS'(1));
  endtask

  task automatic drain_all();
    ivalid = 1'b0;
    oready_pct = 100;
    oready = 1'b1;
    for (int i = 0; i < 300 && exp_data.size() > 0; i++) clk_step();
    chk("drain_empty", OS'(exp_data.size()), OS'(0));
    for (int i = 0; i < 5; i++) clk_step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ovalid"}, OS'(ovalid), OS'(0));
    chk({tag, "_olast"}, OS'(olast), OS'(0));
    chk({tag, "_odata"}, odata, '0);
`ifdef STREAM_PACKER_KEEP_EN
    chk({tag, "_okeep"}, OS'(okeep), OS'(0));
`else
    chk({tag, "_okeep"}, OS'(okeep), OS'({KW{1'b1}}));
`endif
    chk({tag, "_iready"}, OS'(iready), OS'(0));
  endtask

  initial begin
    int st, tot, w0, cnt;
    bit ok;
    logic [OS-1:0] w;
    logic [IS-1:0] a, b;

    // Reset state
    #2;
    chk_reset_outputs("reset");
    for (int i = 0; i < 3; i++) clk_step();
    chk_reset_outputs("reset_hold");
    rst_n = 1'b1;
    clk_step();
    chk("iready_after_reset", OS'(iready), OS'(1));

    // 32 counting beats, no ilast: three words, no input gaps
    oready_pct = 100; oready = 1'b1;
    got_data.delete(); w0 = words_seen; tot = 0;
    for (int k = 0; k < 32; k++) begin
      send_chk(IS'(k), 1'b0, 1'b0, st);
      tot += st;
    end
    drain_all();
    chk("no_iready_gaps", OS'(tot), OS'(0));
    chk("three_words", OS'(words_seen - w0), OS'(3));
    w = '0;
    for (int k = 0; k < 10; k++) w[OS-1-24*k -: 24] = IS'(k);
    w[15:0] = 16'd0;
    w[15:0] = 16'h0000 | 16'(10 >> 8);
    if (got_data.size() > 0) chk("word0_layout", got_data[0], w);

    // Same with ilast on beat 31: word2 flagged last, full keep, no 4th word
    w0 = words_seen; got_keep.delete();
    for (int k = 0; k < 32; k++) send_chk(IS'(k), 1'b0, (k == 31), st);
    drain_all();
    chk("ilast_three_words", OS'(words_seen - w0), OS'(3));
`ifdef STREAM_PACKER_KEEP_EN
    if (got_keep.size() == 3) chk("ilast_keep_full", OS'(got_keep[2]), OS'(32'hFFFFFFFF));
`endif

    // 5 beats, ilast on beat 4: single padded word
    w0 = words_seen; got_data.delete(); got_keep.delete();
    for (int k = 0; k < 5; k++) send_chk(IS'($urandom), 1'b0, (k == 4), st);
    drain_all();
    chk("short_one_word", OS'(words_seen - w0), OS'(1));
    if (got_data.size() == 1) chk("short_pad_zero", OS'(got_data[0][135:0]), '0);
`ifdef STREAM_PACKER_KEEP_EN
    if (got_keep.size() == 1) chk("short_keep", OS'(got_keep[0]), OS'(32'hFFFE0000));
`endif

    // Backpressure: 22 beats accepted then stall; resume without loss
    oready_pct = 0; oready = 1'b0;
    cnt = 0; ok = 1'b1;
    while (ok && cnt < 40) begin
      send(IS'(100 + cnt), 1'b0, 1'b0, 4, ok, st);
      if (ok) cnt++;
    end
    chk("bp_accepted", OS'(cnt), OS'(22));
    chk("bp_iready_low", OS'(iready), OS'(0));
    oready_pct = 100; oready = 1'b1;
    send_chk(IS'(100 + cnt), 1'b0, 1'b0, st);
    for (int k = 0; k < 3; k++) send_chk(IS'($urandom), 1'b0, (k == 2), st);
    drain_all();

    // Align: 3 beats, then A with ialign, then 10 more
    got_data.delete();
    a = IS'($urandom) | 24'h800001;
    for (int k = 0; k < 3; k++) send_chk(IS'($urandom), 1'b0, 1'b0, st);
    send_chk(a, 1'b1, 1'b0, st);
    for (int k = 0; k < 10; k++) send_chk(IS'($urandom), 1'b0, (k == 9), st);
    drain_all();
    if (got_data.size() > 0) chk("align_msb", OS'(got_data[0][255:232]), OS'(a));

    // Randomised traffic against the model
    oready_pct = 60;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) clk_step();
      send_chk(IS'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), st);
    end
    send_chk(IS'($urandom), 1'b0, 1'b1, st);
    drain_all();

    // Reset mid-packet: outputs zero, next packet starts clean
    oready_pct = 100; oready = 1'b1;
    for (int k = 0; k < 5; k++) send_chk(IS'($urandom), 1'b0, 1'b0, st);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    mq.delete(); exp_data.delete(); exp_keep.delete(); exp_last.delete();
    clk_step();
    rst_n = 1'b1;
    clk_step();
    got_data.delete(); w0 = words_seen;
    b = IS'($urandom) | 24'h400002;
    for (int k = 0; k < 11; k++) send_chk((k == 0) ? b : IS'($urandom), 1'b0, (k == 10), st);
    drain_all();
    chk("post_reset_words", OS'(words_seen - w0), OS'(2));
    if (got_data.size() > 0) chk("post_reset_msb", OS'(got_data[0][255:232]), OS'(b));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
